// File: rtl/scrambler_pkg.sv
// Shared definitions for the parallel scrambler: operating modes.
package scrambler_pkg;

    typedef enum logic [1:0] {
        MODE_ADD      = 2'd0,
        MODE_SS_SCR   = 2'd1,
        MODE_SS_DESCR = 2'd2,
        MODE_BYPASS   = 2'd3
    } mode_e;

endpackage

// File: rtl/par_scrambler_if.sv
// Word stream, handshake and seed/mode load signals of the parallel scrambler.
interface par_scrambler_if #(
    parameter int DATA_W = 8,
    parameter int LFSR_W = 31
) ();
    logic              load;
    logic [LFSR_W-1:0] seed;
    logic [1:0]        mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              seed_err;

    modport master (
        output load, seed, mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, seed_err
    );

    modport slave (
        input  load, seed, mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, seed_err
    );
endinterface

// File: rtl/scrambler_core.sv
// Combinational unroll of DATA_W scrambler bit-steps, bit 0 processed first.
module scrambler_core
    import scrambler_pkg::*;
#(
    parameter int LFSR_W = 31,
    parameter int DATA_W = 8,
    parameter int TAP_A  = 30,
    parameter int TAP_B  = 27
) (
    input  logic [LFSR_W-1:0] state_i,
    input  logic [DATA_W-1:0] data_i,
    input  mode_e             mode_i,
    output logic [LFSR_W-1:0] state_o,
    output logic [DATA_W-1:0] data_o
);
    logic [LFSR_W-1:0] s;
    logic              ob;
    logic              fb;

    always_comb begin
        s      = state_i;
        data_o = '0;
        ob     = 1'b0;
        fb     = 1'b0;
        for (int k = 0; k < DATA_W; k++) begin
            case (mode_i)
                MODE_ADD: begin
                    ob = data_i[k] ^ s[TAP_A];
                    fb = s[TAP_A] ^ s[TAP_B];
                end
                MODE_SS_SCR: begin
                    ob = data_i[k] ^ s[TAP_A] ^ s[TAP_B];
                    fb = ob;
                end
                MODE_SS_DESCR: begin
                    ob = data_i[k] ^ s[TAP_A] ^ s[TAP_B];
                    fb = data_i[k];
                end
                default: begin
                    ob = data_i[k];
                    fb = 1'b0;
                end
            endcase
            data_o[k] = ob;
            // Bypass leaves the register untouched so a later mode resumes where it left off.
            if (mode_i != MODE_BYPASS) begin
                s = {s[LFSR_W-2:0], fb};
            end
        end
        state_o = s;
    end
endmodule

// File: rtl/par_scrambler.sv
// Parallel LFSR scrambler/descrambler with handshake, runtime seed/mode load and periodic re-seed.
module par_scrambler
    import scrambler_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                LFSR_W      = 31,
    parameter int                TAP_A       = 30,
    parameter int                TAP_B       = 27,
    parameter logic [LFSR_W-1:0] RESET_SEED  = 31'h7FFFFFFF,
    parameter int                FRAME_WORDS = 0
) (
    input logic           clk,
    input logic           reset,
    par_scrambler_if.slave bus
);
    localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FRAME_WORDS > 0) ? FRAME_WORDS - 1 : 0);
    localparam logic [LFSR_W-1:0] ONE_STATE = {{(LFSR_W-1){1'b0}}, 1'b1};

    logic [LFSR_W-1:0] state_q, state_d;
    logic [LFSR_W-1:0] seed_q, seed_d;
    mode_e             mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              seed_err_q, seed_err_d;

    logic [LFSR_W-1:0] core_state;
    logic [DATA_W-1:0] core_data;
    mode_e             ld_mode;
    logic              ld_zero;
    logic [LFSR_W-1:0] ld_state;
    logic [LFSR_W-1:0] reseed_state;
    logic              in_ready;
    logic              accept;

    scrambler_core #(
        .LFSR_W (LFSR_W),
        .DATA_W (DATA_W),
        .TAP_A  (TAP_A),
        .TAP_B  (TAP_B)
    ) u_core (
        .state_i (state_q),
        .data_i  (bus.in_data),
        .mode_i  (mode_q),
        .state_o (core_state),
        .data_o  (core_data)
    );

    // An all-zero additive LFSR would lock up, so a zero seed is replaced by a single set LSB.
    assign ld_mode      = mode_e'(bus.mode);
    assign ld_zero      = (ld_mode == MODE_ADD) && (bus.seed == '0);
    assign ld_state     = ld_zero ? ONE_STATE : bus.seed;
    assign reseed_state = (seed_q == '0) ? ONE_STATE : seed_q;

    assign in_ready = !bus.load && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        seed_err_d  = seed_err_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (bus.load) begin
            seed_d     = bus.seed;
            mode_d     = ld_mode;
            state_d    = ld_state;
            seed_err_d = ld_zero;
            cnt_d      = '0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = core_data;
            state_d     = core_state;
            if ((FRAME_WORDS > 0) && (mode_q == MODE_ADD)) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = reseed_state;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_SEED;
            seed_q      <= RESET_SEED;
            mode_q      <= MODE_ADD;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            seed_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            seed_err_q  <= seed_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.seed_err  = seed_err_q;
endmodule

// File: doc/par_scrambler.md
# par_scrambler

Parametrised, multi-bit-per-clock successor to the serial LFSR scrambler. It processes DATA_W bits per accepted word, bit 0 first in time. It supports three modes: additive (frame-synchronous), self-synchronising multiplicative scramble, and self-synchronising multiplicative descramble. It has a valid/ready handshake on both sides, runtime seed and mode loading, and optional periodic re-seeding. It sits between the framer and the serialiser on TX, or between the deserialiser and the deframer on RX.

## Interface
Parameters:
- DATA_W, default 8: bits per word; 1..64.
- LFSR_W, default 31: LFSR length; 8..32.
- TAP_A, default 30: first feedback tap index; must be LFSR_W-1.
- TAP_B, default 27: second feedback tap index; < TAP_A.
- RESET_SEED, default 31'h7FFFFFFF: LFSR state after reset.
- FRAME_WORDS, default 0: additive-mode re-seed period in words; 0 disables re-seeding.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: synchronous, active-high.
- load, in, 1: load seed and mode this cycle.
- seed, in, LFSR_W: seed value for load.
- mode, in, 2: 0 additive, 1 self-sync scramble, 2 self-sync descramble, 3 bypass.
- in_valid, in, 1: input word valid.
- in_ready, out, 1: block accepts input.
- in_data, in, DATA_W: input word.
- out_valid, out, 1: output word valid.
- out_ready, in, 1: downstream accepts output.
- out_data, out, DATA_W: output word.
- seed_err, out, 1: sticky flag; last additive load had a zero seed.

## Operation
- Per-bit step for bit k (k = 0..DATA_W-1), with s the current state:
  - Additive: out_k = in_k ^ s[TAP_A]; next s = {s[LFSR_W-2:0], s[TAP_A]^s[TAP_B]}.
  - Self-sync scramble: out_k = in_k ^ s[TAP_A] ^ s[TAP_B]; next s = {s[LFSR_W-2:0], out_k}.
  - Self-sync descramble: out_k = in_k ^ s[TAP_A] ^ s[TAP_B]; next s = {s[LFSR_W-2:0], in_k}.
  - Bypass: out_k = in_k; state unchanged.
- Each accepted word applies all DATA_W steps, bit 0 first.
- Accept happens when in_valid && in_ready. On accept, out_data and out_valid load and the state advances by DATA_W steps.
- in_ready = !load && (!out_valid || out_ready).
- Load:
  - seed_reg and mode_reg are latched, and state <= seed.
  - In additive mode with seed == 0: state <= 1 (LSB set) and seed_err is set.
  - A load with a nonzero seed or non-additive mode clears seed_err.
  - The word counter clears.
  - Load does not flush a pending output word.
- Re-seed (FRAME_WORDS > 0, additive mode only):
  - A word counter increments on each accept.
  - On the accept that brings the count to FRAME_WORDS, the next state is seed_reg (zero substituted as above), not the advanced value, and the counter returns to 0.
- Reset values:
  - state = RESET_SEED; seed_reg = RESET_SEED; mode_reg = 0; counter = 0.
  - out_valid = 0; out_data = 0; seed_err = 0.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: one word per clock while out_ready stays high.
- out_data and out_valid hold stable while out_valid && !out_ready.
- When no accept occurs, the state does not advance (including in bypass).
- Load and in_valid asserted in the same cycle: load wins, and the input is not accepted (in_ready = 0).
- Load and output handshake in the same cycle: the output drains normally.
- Reset mid-stream: the pending output is dropped (out_valid = 0) and state = RESET_SEED on the next edge.
- A mode change takes effect only through load. The mode port is ignored at all other times.

## Structure
- Package scrambler_pkg holds the mode constants: MODE_ADD = 0, MODE_SS_SCR = 1, MODE_SS_DESCR = 2, MODE_BYPASS = 3.
- Sub-module scrambler_core: purely combinational DATA_W-step unroll.
  - Inputs: state, in_data, mode.
  - Outputs: next state and output word.
  - Parameters: LFSR_W, DATA_W, TAP_A, TAP_B.
- Top level holds the registers, handshake, load and re-seed logic.

## Test plan
- Additive known answer: defaults; after reset, feed four words of in_data 0x00 -> out_data 0xFF, 0xFF, 0xFF, 0x7F.
- Self-sync round trip: scrambler (mode 1, seed 0x1234567) feeds a descrambler (mode 2, seed 0x0) with 64 random words -> descrambled words 4 onward equal the originals; words 0..3 may differ.
- Zero seed: load seed = 0 in mode 0 -> seed_err = 1, and the next 0x00 input yields out_data 0x00 with the LFSR nonzero. A load of seed 0x5 then clears seed_err.
- Backpressure: in_valid held high with out_ready low for 3 cycles -> in_ready = 0, out_data stable, and the output sequence is identical to the no-stall run.
- Re-seed: FRAME_WORDS = 4, additive, seed 0x7FFFFFFF, 8 words of 0x00 -> words 4..7 equal words 0..3 (0xFF, 0xFF, 0xFF, 0x7F).
- Load/valid collision and reset mid-stream: load with in_valid high -> word not accepted. Reset with out_valid high -> out_valid = 0 next cycle and RESET_SEED restored.
